// File: rtl/reorder_buffer_pkg.sv
// Shared types and helpers for the reorder buffer: op-type encodings,
// the default id width and the small decode helpers used at issue and commit.
package reorder_buffer_pkg;

    localparam int ROB_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2,
        ROB_EXIT   = 2'd3
    } rob_type_e;

    // Ops that carry a destination register value into the register file.
    function automatic logic writes_reg(input rob_type_e t);
        return (t == ROB_REG) || (t == ROB_BRANCH);
    endfunction

    // Fetch restart address after a mispredicted branch.
    function automatic logic [31:0] redirect_target(input logic        actual_jump,
                                                    input logic [31:0] target,
                                                    input logic [31:0] pc);
        return actual_jump ? target : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue. Allocates one id per issued op, captures
// ALU/LSB results, answers register-file operand queries (with CDB bypass),
// and retires one op per cycle, flushing everything on a branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                issue_valid,
    input  logic [1:0]          issue_type,
    input  logic [4:0]          issue_rd,
    input  logic                issue_pred_jump,
    input  logic [31:0]         issue_pc,
    output logic                rob_full,
    output logic [ROB_BITS-1:0] tail_id,
    output logic                need_set_reg_dep,
    output logic [4:0]          set_dep_reg_id,
    output logic [ROB_BITS-1:0] set_dep_rob_id,
    input  logic                alu_valid,
    input  logic [ROB_BITS-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    input  logic                alu_jump,
    input  logic [31:0]         alu_target,
    input  logic                lsb_valid,
    input  logic [ROB_BITS-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    input  logic [ROB_BITS-1:0] need_rob_id1,
    input  logic [ROB_BITS-1:0] need_rob_id2,
    output logic                rob_value1_ready,
    output logic [31:0]         rob_value1,
    output logic                rob_value2_ready,
    output logic [31:0]         rob_value2,
    output logic                need_set_reg_value,
    output logic [4:0]          set_value_reg_id,
    output logic [31:0]         set_val,
    output logic [ROB_BITS-1:0] set_reg_rob_id,
    output logic                commit_store,
    output logic [ROB_BITS-1:0] commit_rob_id,
    output logic                clear,
    output logic [31:0]         redirect_pc,
    output logic                halt
);

    localparam int                DEPTH    = 1 << ROB_BITS;
    localparam logic [ROB_BITS:0] FULL_CNT = (ROB_BITS + 1)'(DEPTH);

    logic [ROB_BITS-1:0] r_head, r_tail;
    logic [ROB_BITS:0]   r_count;
    logic [DEPTH-1:0]    r_busy, r_ready;
    rob_type_e           r_type   [DEPTH];
    logic [4:0]          r_rd     [DEPTH];
    logic [31:0]         r_value  [DEPTH];
    logic                r_pred   [DEPTH];
    logic                r_actual [DEPTH];
    logic [31:0]         r_target [DEPTH];
    logic [31:0]         r_pc     [DEPTH];

    logic                r_need_set_reg_value, r_commit_store, r_clear, r_halt;
    logic [4:0]          r_set_value_reg_id;
    logic [31:0]         r_set_val, r_redirect_pc;
    logic [ROB_BITS-1:0] r_set_reg_rob_id, r_commit_rob_id;

    logic                w_issue, w_alu_head, w_lsb_head, w_head_ready, w_commit;
    logic                w_head_actual, w_mispredict;
    logic [31:0]         w_head_value, w_head_target;
    rob_type_e           w_issue_type, w_head_type;

    // Issue is blocked by the registered count and while a flush is in flight.
    assign w_issue_type     = rob_type_e'(issue_type);
    assign rob_full         = (r_count == FULL_CNT);
    assign w_issue          = issue_valid & ~rob_full & ~r_clear;
    assign tail_id          = r_tail;
    assign need_set_reg_dep = w_issue & writes_reg(w_issue_type) & (issue_rd != 5'd0);
    assign set_dep_reg_id   = issue_rd;
    assign set_dep_rob_id   = r_tail;

    // Operand queries see a result on the CDB in the same cycle it is broadcast.
    assign rob_value1_ready = r_ready[need_rob_id1] | (alu_valid & (alu_rob_id == need_rob_id1))
                            | (lsb_valid & (lsb_rob_id == need_rob_id1));
    assign rob_value1       = (alu_valid & (alu_rob_id == need_rob_id1)) ? alu_value :
                              (lsb_valid & (lsb_rob_id == need_rob_id1)) ? lsb_value : r_value[need_rob_id1];
    assign rob_value2_ready = r_ready[need_rob_id2] | (alu_valid & (alu_rob_id == need_rob_id2))
                            | (lsb_valid & (lsb_rob_id == need_rob_id2));
    assign rob_value2       = (alu_valid & (alu_rob_id == need_rob_id2)) ? alu_value :
                              (lsb_valid & (lsb_rob_id == need_rob_id2)) ? lsb_value : r_value[need_rob_id2];

    // The head may retire on the same edge its result arrives on the CDB.
    assign w_alu_head    = alu_valid & (alu_rob_id == r_head);
    assign w_lsb_head    = lsb_valid & (lsb_rob_id == r_head);
    assign w_head_ready  = r_ready[r_head] | w_alu_head | w_lsb_head;
    assign w_head_value  = w_alu_head ? alu_value : (w_lsb_head ? lsb_value : r_value[r_head]);
    assign w_head_actual = w_alu_head ? alu_jump : r_actual[r_head];
    assign w_head_target = w_alu_head ? alu_target : r_target[r_head];
    assign w_head_type   = r_type[r_head];
    assign w_commit      = ~r_clear & r_busy[r_head] & w_head_ready;
    assign w_mispredict  = w_commit & (w_head_type == ROB_BRANCH) & (w_head_actual != r_pred[r_head]);

    assign need_set_reg_value = r_need_set_reg_value;
    assign set_value_reg_id   = r_set_value_reg_id;
    assign set_val            = r_set_val;
    assign set_reg_rob_id     = r_set_reg_rob_id;
    assign commit_store       = r_commit_store;
    assign commit_rob_id      = r_commit_rob_id;
    assign clear              = r_clear;
    assign redirect_pc        = r_redirect_pc;
    assign halt               = r_halt;

    // Queue pointers, entry status bits and registered commit/flush outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head               <= '0;
            r_tail               <= '0;
            r_count              <= '0;
            r_busy               <= '0;
            r_ready              <= '0;
            r_need_set_reg_value <= 1'b0;
            r_set_value_reg_id   <= '0;
            r_set_val            <= '0;
            r_set_reg_rob_id     <= '0;
            r_commit_store       <= 1'b0;
            r_commit_rob_id      <= '0;
            r_clear              <= 1'b0;
            r_redirect_pc        <= '0;
            r_halt               <= 1'b0;
        end else if (rdy) begin
            r_need_set_reg_value <= 1'b0;
            r_commit_store       <= 1'b0;
            r_clear              <= 1'b0;
            if (r_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_busy  <= '0;
                r_ready <= '0;
            end else begin
                if (alu_valid) r_ready[alu_rob_id] <= 1'b1;
                if (lsb_valid) r_ready[lsb_rob_id] <= 1'b1;
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_head          <= r_head + ROB_BITS'(1);
                    r_commit_rob_id <= r_head;
                    case (w_head_type)
                        ROB_REG, ROB_BRANCH: begin
                            if (r_rd[r_head] != 5'd0) begin
                                r_need_set_reg_value <= 1'b1;
                                r_set_value_reg_id   <= r_rd[r_head];
                                r_set_val            <= w_head_value;
                                r_set_reg_rob_id     <= r_head;
                            end
                        end
                        ROB_STORE: r_commit_store <= 1'b1;
                        ROB_EXIT:  r_halt         <= 1'b1;
                        default: ;
                    endcase
                    if (w_mispredict) begin
                        r_clear       <= 1'b1;
                        r_redirect_pc <= redirect_target(w_head_actual, w_head_target, r_pc[r_head]);
                    end
                end
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + ROB_BITS'(1);
                end
                r_count <= r_count + (ROB_BITS + 1)'(w_issue) - (ROB_BITS + 1)'(w_commit);
            end
        end
    end

    // Entry payload fields; only meaningful while the matching busy bit is set.
    always_ff @(posedge clk) begin
        if (rdy && !r_clear) begin
            if (alu_valid) begin
                r_value[alu_rob_id]  <= alu_value;
                r_actual[alu_rob_id] <= alu_jump;
                r_target[alu_rob_id] <= alu_target;
            end
            if (lsb_valid) r_value[lsb_rob_id] <= lsb_value;
            if (w_issue) begin
                r_type[r_tail] <= w_issue_type;
                r_rd[r_tail]   <= issue_rd;
                r_pred[r_tail] <= issue_pred_jump;
                r_pc[r_tail]   <= issue_pc;
            end
        end
    end

endmodule
